// File: rtl/riscv_core_pkg.sv
// Shared fetch-stage types: address/word widths, FSM encoding and FIFO entry layout.
package riscv_core_pkg;

   localparam int unsigned ADDR_WIDTH = 32;
   localparam int unsigned WORD_WIDTH = 32;

   typedef logic [ADDR_WIDTH-1:0] addr_t;
   typedef logic [WORD_WIDTH-1:0] word_t;

   localparam addr_t DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic {
      F_RUN  = 1'b0,
      F_MISS = 1'b1
   } fetch_state_e;

   typedef struct packed {
      addr_t pc;
      word_t instr;
   } fq_entry_t;

   function automatic addr_t word_align(input addr_t a);
      return {a[ADDR_WIDTH-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Generic DEPTH-entry synchronous FIFO with flush; head visible the cycle after push, zero when empty.
// Push is refused when full unless a pop happens in the same cycle; flush wins over push/pop.
module fetch_fifo
   import riscv_core_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter type         T     = fq_entry_t
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  T                         data_i,
   input  logic                     pop_i,
   output T                         data_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   T              mem_q [DEPTH];
   logic          push_ok, pop_ok;

   assign pop_ok  = pop_i & (count_q != '0);
   assign push_ok = push_i & ((count_q < CW'(DEPTH)) | pop_ok);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
         if (push_ok && !pop_ok)      count_q <= count_q + CW'(1);
         else if (pop_ok && !push_ok) count_q <= count_q - CW'(1);
      end
   end

   // Storage needs no reset: the head is masked to zero while empty.
   always_ff @(posedge clk_i) begin
      if (push_ok && !flush_i) mem_q[wr_ptr_q] <= data_i;
   end

   assign data_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
   assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch PC owner: issues word requests to icache, queues hit instructions with PCs for decode.
// Hit pushes land at the head next cycle; a miss stalls in F_MISS until icache ready, then replays.
module instr_fetch_queue
   import riscv_core_pkg::*;
#(
   parameter int unsigned DEPTH      = 4,
   parameter addr_t       RESET_PC   = DEFAULT_RESET_PC,
   parameter int unsigned ADDR_WIDTH = riscv_core_pkg::ADDR_WIDTH
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    fetch_en_i,
   input  logic                    redirect_valid_i,
   input  logic [ADDR_WIDTH-1:0]   redirect_pc_i,
   output logic                    ic_req_valid_o,
   output logic [ADDR_WIDTH-1:0]   ic_req_addr_o,
   input  logic                    ic_req_ready_i,
   input  logic                    ic_rsp_valid_i,
   input  logic [31:0]             ic_rsp_data_i,
   input  logic                    ic_rsp_hit_i,
   output logic                    instr_valid_o,
   output logic [31:0]             instr_data_o,
   output logic [ADDR_WIDTH-1:0]   instr_pc_o,
   input  logic                    instr_ready_i,
   output logic [$clog2(DEPTH):0]  fq_count_o,
   output logic [31:0]             perf_miss_cyc_o
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   fetch_state_e          state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [31:0]           perf_q;
   logic [CW-1:0]         count;
   logic                  req_vld, push, pop, has_room, rsp_hit;
   fq_entry_t             push_entry, head;

   assign has_room = count < CW'(DEPTH);
   assign rsp_hit  = ic_rsp_valid_i & ic_rsp_hit_i;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      req_vld = 1'b0;
      push    = 1'b0;
      if (redirect_valid_i) begin
         pc_d = word_align(redirect_pc_i);
         // A pending miss must still see icache go idle before the new target is issued.
         state_d = (state_q == F_MISS && !ic_req_ready_i) ? F_MISS : F_RUN;
      end else begin
         unique case (state_q)
            F_RUN: begin
               req_vld = fetch_en_i & has_room;
               if (req_vld && ic_req_ready_i) begin
                  if (rsp_hit) begin
                     push = 1'b1;
                     pc_d = pc_q + ADDR_WIDTH'(4);
                  end else begin
                     state_d = F_MISS;
                  end
               end
            end
            F_MISS: begin
               if (ic_req_ready_i) state_d = F_RUN;
            end
            default: state_d = F_RUN;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= F_RUN;
         pc_q    <= RESET_PC;
         perf_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         if (state_q == F_MISS && perf_q != '1) perf_q <= perf_q + 32'd1;
      end
   end

   assign pop        = instr_valid_o & instr_ready_i & ~redirect_valid_i;
   assign push_entry = '{pc: pc_q, instr: ic_rsp_data_i};

   fetch_fifo #(
      .DEPTH (DEPTH),
      .T     (fq_entry_t)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (redirect_valid_i),
      .push_i  (push),
      .data_i  (push_entry),
      .pop_i   (pop),
      .data_o  (head),
      .count_o (count)
   );

   assign ic_req_valid_o  = req_vld;
   assign ic_req_addr_o   = pc_q;
   assign instr_valid_o   = count != '0;
   assign instr_data_o    = head.instr;
   assign instr_pc_o      = head.pc;
   assign fq_count_o      = count;
   assign perf_miss_cyc_o = perf_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized bench for instr_fetch_queue: the bench plays icache and decode, a reference model
// predicts every push, and a monitor checks each pop against the expected queue.
module tb_instr_fetch_queue;

   localparam int DEPTH = 4;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        fetch_en_i, redirect_valid_i, ic_req_ready_i, ic_rsp_valid_i, ic_rsp_hit_i;
   logic        instr_ready_i;
   logic [31:0] redirect_pc_i, ic_rsp_data_i;
   logic        ic_req_valid_o, instr_valid_o;
   logic [31:0] ic_req_addr_o, instr_data_o, instr_pc_o, perf_miss_cyc_o;
   logic [2:0]  fq_count_o;

   instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0), .ADDR_WIDTH(32)) dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .fetch_en_i       (fetch_en_i),
      .redirect_valid_i (redirect_valid_i),
      .redirect_pc_i    (redirect_pc_i),
      .ic_req_valid_o   (ic_req_valid_o),
      .ic_req_addr_o    (ic_req_addr_o),
      .ic_req_ready_i   (ic_req_ready_i),
      .ic_rsp_valid_i   (ic_rsp_valid_i),
      .ic_rsp_data_i    (ic_rsp_data_i),
      .ic_rsp_hit_i     (ic_rsp_hit_i),
      .instr_valid_o    (instr_valid_o),
      .instr_data_o     (instr_data_o),
      .instr_pc_o       (instr_pc_o),
      .instr_ready_i    (instr_ready_i),
      .fq_count_o       (fq_count_o),
      .perf_miss_cyc_o  (perf_miss_cyc_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   ent_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   bit          mon_en = 1'b0;

   // Reference state: where fetch is, whether a miss is outstanding, queue occupancy.
   logic [31:0] m_pc   = 32'h0;
   bit          m_miss = 1'b0;
   int          m_cnt  = 0;
   logic [31:0] m_perf = 32'h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_eval();
      bit exp_req, do_push, do_pop;
      exp_req = !m_miss && fetch_en_i && (m_cnt < DEPTH) && !redirect_valid_i;
      chk("req_valid", {31'b0, ic_req_valid_o}, {31'b0, exp_req});
      chk("req_addr", ic_req_addr_o, m_pc);
      chk("instr_valid", {31'b0, instr_valid_o}, {31'b0, m_cnt != 0});
      chk("count", {29'b0, fq_count_o}, 32'(m_cnt));
      chk("perf", perf_miss_cyc_o, m_perf);
      if (m_cnt == 0) chk("empty_head", instr_pc_o | instr_data_o, 32'h0);

      do_pop  = (m_cnt != 0) && instr_ready_i && !redirect_valid_i;
      do_push = exp_req && ic_req_ready_i && ic_rsp_valid_i && ic_rsp_hit_i;

      if (m_miss && m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 1;
      if (redirect_valid_i) begin
         exp_q.delete();
         m_cnt  = 0;
         m_pc   = redirect_pc_i & 32'hFFFF_FFFC;
         m_miss = m_miss && !ic_req_ready_i;
      end else begin
         if (m_miss) begin
            if (ic_req_ready_i) m_miss = 1'b0;
         end else if (exp_req && ic_req_ready_i) begin
            if (do_push) begin
               exp_q.push_back('{pc: m_pc, instr: ic_rsp_data_i});
               m_pc = m_pc + 32'd4;
            end else begin
               m_miss = 1'b1;
            end
         end
         m_cnt = m_cnt + int'(do_push) - int'(do_pop);
      end
   endtask

   task automatic step(input bit en, input bit redir, input logic [31:0] rpc,
                       input bit rdy, input bit rv, input bit hit, input bit dr);
      @(posedge clk_i);
      #1;
      fetch_en_i       = en;
      redirect_valid_i = redir;
      redirect_pc_i    = rpc;
      ic_req_ready_i   = rdy;
      ic_rsp_valid_i   = rv;
      ic_rsp_hit_i     = hit;
      instr_ready_i    = dr;
      ic_rsp_data_i    = $urandom;
      #1;
      model_eval();
   endtask

   // Monitor: every accepted head must match the oldest expected entry.
   initial begin
      ent_t e;
      wait (mon_en);
      forever begin
         @(negedge clk_i);
         if (instr_valid_o && instr_ready_i && !redirect_valid_i) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL pop_unexpected: got pc %h with nothing expected", instr_pc_o);
            end else begin
               e = exp_q.pop_front();
               chk("pop_pc", instr_pc_o, e.pc);
               chk("pop_data", instr_data_o, e.instr);
            end
         end
      end
   end

   initial begin
      rst_ni = 1'b0;
      fetch_en_i = 0; redirect_valid_i = 0; redirect_pc_i = 0;
      ic_req_ready_i = 0; ic_rsp_valid_i = 0; ic_rsp_hit_i = 0;
      ic_rsp_data_i = 0; instr_ready_i = 0;
      #3;
      chk("rst_req_valid", {31'b0, ic_req_valid_o}, 32'h0);
      chk("rst_req_addr", ic_req_addr_o, 32'h0);
      chk("rst_instr_valid", {31'b0, instr_valid_o}, 32'h0);
      chk("rst_count", {29'b0, fq_count_o}, 32'h0);
      chk("rst_perf", perf_miss_cyc_o, 32'h0);
      chk("rst_head", instr_pc_o | instr_data_o, 32'h0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      mon_en = 1'b1;

      // Streaming hits with decode ready.
      repeat (8) step(1, 0, 0, 1, 1, 1, 1);
      // Decode stalls until the queue is full, then resumes.
      repeat (7) step(1, 0, 0, 1, 1, 1, 0);
      chk("full_count", {29'b0, fq_count_o}, 32'd4);
      repeat (3) step(1, 0, 0, 1, 1, 1, 1);

      // Miss, five busy cycles with stray fill beats, idle, then replay.
      step(1, 0, 0, 1, 0, 0, 1);
      for (int k = 0; k < 5; k++) step(1, 0, 0, 0, k[0], 0, 1);
      step(1, 0, 0, 1, 1, 0, 1);
      step(1, 0, 0, 1, 1, 1, 1);
      chk("perf_after_miss", perf_miss_cyc_o, 32'd6);

      // Redirect to a misaligned target with three entries queued.
      repeat (4) step(0, 0, 0, 1, 0, 0, 1);
      repeat (3) step(1, 0, 0, 1, 1, 1, 0);
      step(1, 1, 32'h0000_1002, 1, 1, 1, 0);
      step(0, 0, 0, 1, 0, 0, 1);
      chk("redir_count", {29'b0, fq_count_o}, 32'd0);
      chk("redir_addr", ic_req_addr_o, 32'h0000_1000);
      repeat (4) step(1, 0, 0, 1, 1, 1, 1);

      // Redirect while a miss is outstanding; hit-looking fill beats are ignored.
      step(1, 0, 0, 1, 0, 0, 1);
      step(1, 1, 32'h0000_2000, 0, 1, 0, 1);
      repeat (3) step(1, 0, 0, 0, 1, 1, 1);
      step(1, 0, 0, 1, 1, 1, 1);
      chk("miss_redir_addr", ic_req_addr_o, 32'h0000_2000);
      repeat (4) step(1, 0, 0, 1, 1, 1, 1);

      // Address wrap, then fill and drain with concurrent push/pop.
      step(1, 1, 32'hFFFF_FFFC, 1, 1, 1, 1);
      repeat (4) step(1, 0, 0, 1, 1, 1, 1);
      repeat (6) step(1, 0, 0, 1, 1, 1, 0);
      repeat (6) step(1, 0, 0, 1, 1, 1, 1);

      for (int n = 0; n < 3000; n++) begin
         step($urandom_range(0, 9) != 0,
              $urandom_range(0, 32) == 0,
              $urandom,
              $urandom_range(0, 4) != 0,
              $urandom_range(0, 9) < 7,
              $urandom_range(0, 4) != 0,
              $urandom_range(0, 9) < 7);
      end

      repeat (12) step(0, 0, 0, 1, 0, 0, 1);
      chk("drain_left", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
